adrv9001_rx_ramp_checker: RTL and testbench

- Sits directly downstream of the ADRV9001 RX channel interface in loopback setups (TX1/TX2 ramp → RX1/RX2).
- Consumes per-sample I/Q words qualified by adc_valid.
- Locks onto a free-running 16-bit ramp on each of I and Q independently, then counts mismatches.
- Reports lock, loss-of-sync and error statistics to the bench and to a status register.

---
 rtl/adrv9001_rx_ramp_checker_if.sv | 21 ++
 rtl/adrv9001_rx_ramp_checker.sv | 145 ++++++++++++++
 tb/tb_adrv9001_rx_ramp_checker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/adrv9001_rx_ramp_checker_if.sv
// RX sample stream from the ADRV9001 channel interface: one I/Q pair per
// cycle, qualified by adc_valid.
interface adrv9001_rx_ramp_checker_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  adc_valid;
    logic [DATA_WIDTH-1:0] adc_data_i;
    logic [DATA_WIDTH-1:0] adc_data_q;

    modport master (
        output adc_valid,
        output adc_data_i,
        output adc_data_q
    );

    modport slave (
        input adc_valid,
        input adc_data_i,
        input adc_data_q
    );
endinterface

// File: rtl/adrv9001_rx_ramp_checker.sv
// Loopback ramp checker: locks onto an incrementing ramp on I and Q, then
// counts mismatching samples and reports loss of sync.
module adrv9001_rx_ramp_checker #(
    parameter int DATA_WIDTH    = 16,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int ERR_CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear_counters,
    adrv9001_rx_ramp_checker_if.slave    adc,
    output logic                         locked,
    output logic                         error,
    output logic                         oos_sticky,
    output logic [ERR_CNT_WIDTH-1:0]     err_count,
    output logic [ERR_CNT_WIDTH-1:0]     sample_count
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

    // Last count value before the threshold; reaching it with one more
    // sample completes the lock (or unlock) condition.
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
    } state_t;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                state;
    logic [DATA_WIDTH-1:0] expected_i;
    logic [DATA_WIDTH-1:0] expected_q;
    logic [GOOD_W-1:0]     good_cnt;
    logic [BAD_W-1:0]      bad_cnt;

    // Stage p0: compare incoming sample against the running expectation
    logic                     vld_p0;
    logic                     match_p0;
    logic [DATA_WIDTH-1:0]    seed_i_p0;
    logic [DATA_WIDTH-1:0]    seed_q_p0;
    logic [ERR_CNT_WIDTH-1:0] err_base_p0;
    logic [ERR_CNT_WIDTH-1:0] smp_base_p0;
    logic                     oos_base_p0;

    assign vld_p0    = adc.adc_valid;
    assign match_p0  = (adc.adc_data_i == expected_i) && (adc.adc_data_q == expected_q);
    assign seed_i_p0 = adc.adc_data_i + 1'b1;
    assign seed_q_p0 = adc.adc_data_q + 1'b1;

    // A clear coincident with a counted event is applied first, so the
    // event then lands on a zeroed counter.
    assign err_base_p0 = clear_counters ? '0 : err_count;
    assign smp_base_p0 = clear_counters ? '0 : sample_count;
    assign oos_base_p0 = clear_counters ? 1'b0 : oos_sticky;

    // Stage p1: FSM, counters and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            expected_i   <= '0;
            expected_q   <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            locked       <= 1'b0;
            error        <= 1'b0;
            oos_sticky   <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            error        <= 1'b0;
            err_count    <= err_base_p0;
            sample_count <= smp_base_p0;
            oos_sticky   <= oos_base_p0;

            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= SEARCH;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end

                    SEARCH: begin
                        // good_cnt==0 marks "not yet seeded" since entry
                        if (vld_p0) begin
                            if (good_cnt == '0 || !match_p0) begin
                                expected_i <= seed_i_p0;
                                expected_q <= seed_q_p0;
                                good_cnt   <= GOOD_W'(1);
                            end else begin
                                expected_i <= expected_i + 1'b1;
                                expected_q <= expected_q + 1'b1;
                                good_cnt   <= good_cnt + 1'b1;
                                if (good_cnt == LOCK_LAST) begin
                                    state   <= LOCKED;
                                    locked  <= 1'b1;
                                    bad_cnt <= '0;
                                end
                            end
                        end
                    end

                    LOCKED: begin
                        // Once locked the expectation free-runs; data never reseeds it
                        if (vld_p0) begin
                            sample_count <= sat_inc(smp_base_p0);
                            expected_i   <= expected_i + 1'b1;
                            expected_q   <= expected_q + 1'b1;
                            if (match_p0) begin
                                bad_cnt <= '0;
                            end else begin
                                err_count <= sat_inc(err_base_p0);
                                error     <= 1'b1;
                                bad_cnt   <= bad_cnt + 1'b1;
                                if (bad_cnt == UNLOCK_LAST) begin
                                    state      <= SEARCH;
                                    locked     <= 1'b0;
                                    oos_sticky <= 1'b1;
                                    good_cnt   <= '0;
                                end
                            end
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adrv9001_rx_ramp_checker.sv
// Scoreboard bench for adrv9001_rx_ramp_checker: directed ramp vectors with
// hand-derived expected status after each clock edge.
module tb_adrv9001_rx_ramp_checker;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        clear_counters;
    logic        locked;
    logic        error;
    logic        oos_sticky;
    logic [31:0] err_count;
    logic [31:0] sample_count;

    adrv9001_rx_ramp_checker_if #(.DATA_WIDTH(16)) adc_if ();

    adrv9001_rx_ramp_checker dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .clear_counters (clear_counters),
        .adc            (adc_if.slave),
        .locked         (locked),
        .error          (error),
        .oos_sticky     (oos_sticky),
        .err_count      (err_count),
        .sample_count   (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        lk;
        logic        er;
        logic        oo;
        logic [31:0] ec;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];
    exp_t r;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, expv);
        end
    endtask

    // Drive one cycle of stimulus and queue the status expected after its edge
    task automatic step(input logic en, input logic v, input logic [15:0] di, input logic [15:0] dq,
                        input logic clr, input logic el, input logic ee, input logic [31:0] ec,
                        input logic [31:0] sc, input logic eo);
        exp_t e;
        @(negedge clk);
        enable            = en;
        adc_if.adc_valid  = v;
        adc_if.adc_data_i = di;
        adc_if.adc_data_q = dq;
        clear_counters    = clr;
        e.idx = step_no;
        e.lk  = el;
        e.er  = ee;
        e.oo  = eo;
        e.ec  = ec;
        e.sc  = sc;
        sb.push_back(e);
        step_no++;
    endtask

    // Monitor: status is presented every cycle; pop one expectation per edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("locked", r.idx, {31'b0, locked}, {31'b0, r.lk});
            chk("error", r.idx, {31'b0, error}, {31'b0, r.er});
            chk("oos_sticky", r.idx, {31'b0, oos_sticky}, {31'b0, r.oo});
            chk("err_count", r.idx, err_count, r.ec);
            chk("sample_count", r.idx, sample_count, r.sc);
        end
    end

    initial begin
        logic [15:0] v;
        rst               = 1'b1;
        enable            = 1'b0;
        clear_counters    = 1'b0;
        adc_if.adc_valid  = 1'b0;
        adc_if.adc_data_i = '0;
        adc_if.adc_data_q = '0;
        #1;
        chk("rst_locked", -1, {31'b0, locked}, 32'd0);
        chk("rst_error", -1, {31'b0, error}, 32'd0);
        chk("rst_oos", -1, {31'b0, oos_sticky}, 32'd0);
        chk("rst_err_count", -1, err_count, 32'd0);
        chk("rst_sample_count", -1, sample_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean ramp from 0x1234: lock after 16th sample, 8 counted of 24
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 24; k++) begin
            v = 16'(16'h1234 + k);
            step(1, 1, v, v, 0, k >= 15, 0, 0, (k >= 16) ? 32'(k - 15) : 32'd0, 0);
        end

        // Re-enable with a fresh seed at 0x00F0, then single I corruption at 0x0100
        step(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 8, 0);
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 8, 0);
        for (int k = 0; k < 16; k++) begin
            v = 16'(16'h00F0 + k);
            step(1, 1, v, v, 0, k == 15, 0, 0, 8, 0);
        end
        step(1, 1, 16'hDEAD, 16'h0100, 0, 1, 1, 1, 9, 0);
        step(1, 1, 16'h0101, 16'h0101, 0, 1, 0, 1, 10, 0);
        for (int k = 2; k < 5; k++) begin
            v = 16'(16'h0100 + k);
            step(1, 1, v, v, 0, 1, 0, 1, 32'(k + 9), 0);
        end
        // Clear coincident with a counted clean sample: sample_count lands on 1
        step(1, 1, 16'h0105, 16'h0105, 1, 1, 0, 0, 1, 0);

        // Four consecutive corruptions: unlock on the 4th
        for (int k = 0; k < 4; k++) begin
            v = 16'(16'h0106 + k);
            step(1, 1, ~v, v, 0, k < 3, 1, 32'(k + 1), 32'(k + 2), k == 3);
        end
        for (int k = 0; k < 16; k++) begin
            v = 16'(16'h0200 + k);
            step(1, 1, v, v, 0, k == 15, 0, 4, 5, 1);
        end

        // Wrap through 0xFFFF with valid gaps carrying junk data
        step(0, 0, 16'h0, 16'h0, 0, 0, 0, 4, 5, 1);
        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 4, 5, 1);
        for (int k = 0; k < 16; k++) begin
            v = 16'(16'hFFEE + k);
            step(1, 1, v, v, 0, k == 15, 0, 4, 5, 1);
        end
        for (int k = 0; k < 4; k++) begin
            v = 16'(16'hFFFE + k);
            step(1, 1, v, v, 0, 1, 0, 4, 32'(k + 6), 1);
            step(1, 0, 16'hAAAA, 16'h5555, 0, 1, 0, 4, 32'(k + 6), 1);
        end

        // Clear coincident with a mismatch, then a clear on its own
        step(1, 1, 16'h0002, 16'hBEEF, 1, 1, 1, 1, 1, 0);
        step(1, 1, 16'h0003, 16'h0003, 0, 1, 0, 1, 2, 0);
        step(1, 0, 16'h0, 16'h0, 1, 1, 0, 0, 0, 0);
        step(1, 1, 16'h0004, 16'h0004, 0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            v = 16'(16'h0005 + k);
            step(1, 1, v, v ^ 16'h8000, 0, k < 3, 1, 32'(k + 1), 32'(k + 2), k == 3);
        end
        for (int k = 0; k < 18; k++) begin
            v = 16'(16'h3000 + k);
            step(1, 1, v, v, 0, k >= 15, 0, 4, (k >= 16) ? 32'(k - 10) : 32'd5, 1);
        end

        // Asynchronous reset between edges while locked with nonzero status
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", -2, {31'b0, locked}, 32'd0);
        chk("arst_oos", -2, {31'b0, oos_sticky}, 32'd0);
        chk("arst_err_count", -2, err_count, 32'd0);
        chk("arst_sample_count", -2, sample_count, 32'd0);
        #1;
        rst = 1'b0;

        step(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            v = 16'(16'h4000 + k);
            step(1, 1, v, v, 0, k >= 15, 0, 0, (k == 16) ? 32'd1 : 32'd0, 0);
        end

        @(negedge clk);
        adc_if.adc_valid = 1'b0;
        for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
